// File: rtl/dp_ram_clr.sv
// dp_ram_clr: parametrised true dual-port RAM with a hardware clear sequencer.
//
// Two independent masters share one buffer. Each port has an access enable,
// a write/read select, byte enables and a valid-tagged registered read path.
// Simultaneous writes to the same address merge byte-wise with port A
// winning, and raise a one-cycle collision pulse. Cross-port
// read-during-write returns old data (RDW_MODE=0) or the byte-merged new
// data (RDW_MODE=1). After reset, or on a clr request in READY, every entry
// is zeroed one per cycle while busy is high and port requests are ignored.
//
// Optional build macro: DP_RAM_OUT_REG_EN adds a second output register
// stage on data_out/valid (read latency 2 instead of 1).
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   clr                     request a full clear (honoured only in READY)
//   en_X, we_X, be_X        per-port enable, write select, byte enables
//   addr_X, data_in_X       per-port address and write data
//   data_out_X, valid_X     per-port read data and its one-cycle valid tag
//   busy                    clear sequence running
//   collision               both ports wrote the same address last cycle
module dp_ram_clr #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en_A,
  input  logic                    we_A,
  input  logic [DATA_WIDTH/8-1:0] be_A,
  input  logic [ADDR_WIDTH-1:0]   addr_A,
  input  logic [DATA_WIDTH-1:0]   data_in_A,
  output logic [DATA_WIDTH-1:0]   data_out_A,
  output logic                    valid_A,
  input  logic                    en_B,
  input  logic                    we_B,
  input  logic [DATA_WIDTH/8-1:0] be_B,
  input  logic [ADDR_WIDTH-1:0]   addr_B,
  input  logic [DATA_WIDTH-1:0]   data_in_B,
  output logic [DATA_WIDTH-1:0]   data_out_B,
  output logic                    valid_B,
  output logic                    busy,
  output logic                    collision
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clrCnt_q, clrCnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wrA, wrB, rdA, rdB;
  logic [DATA_WIDTH-1:0] rdDataA, rdDataB;
  logic [DATA_WIDTH-1:0] dataA_q, dataB_q;
  logic                  validA_q, validB_q;
  logic                  collision_q;

  // Overlay the enabled bytes of a write onto an existing word.
  function automatic logic [DATA_WIDTH-1:0] mergeBytes(
    input logic [DATA_WIDTH-1:0] oldWord,
    input logic [DATA_WIDTH-1:0] newWord,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = oldWord;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[i*8 +: 8] = newWord[i*8 +: 8];
    end
    return res;
  endfunction

  assign busy = (state_q == CLEAR);

  // Port requests are masked out entirely while the clear is running.
  assign wrA = en_A &  we_A & ~busy;
  assign rdA = en_A & ~we_A & ~busy;
  assign wrB = en_B &  we_B & ~busy;
  assign rdB = en_B & ~we_B & ~busy;

  // Clear sequencer: walk the counter from 0 to DEPTH-1, then hand over.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    case (state_q)
      CLEAR: begin
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == LAST_ADDR) state_d = READY;
      end
      READY: begin
        if (clr) begin
          state_d  = CLEAR;
          clrCnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  // Port B bytes are written before port A bytes so that A overrides B on
  // any byte both ports enable for the same address.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clrCnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wrB && be_B[i]) mem[addr_B][i*8 +: 8] <= data_in_B[i*8 +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (wrA && be_A[i]) mem[addr_A][i*8 +: 8] <= data_in_A[i*8 +: 8];
      end
    end
  end

  // In bypass mode a read that hits the other port's write address sees the
  // word as it will look after this edge's write.
  always_comb begin
    rdDataA = mem[addr_A];
    rdDataB = mem[addr_B];
    if (RDW_MODE != 0) begin
      if (wrB && (addr_B == addr_A)) rdDataA = mergeBytes(mem[addr_A], data_in_B, be_B);
      if (wrA && (addr_A == addr_B)) rdDataB = mergeBytes(mem[addr_B], data_in_A, be_A);
    end
  end

  // First output stage: data only moves on a served read, valid is a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataA_q     <= '0;
      dataB_q     <= '0;
      validA_q    <= 1'b0;
      validB_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      validA_q    <= rdA;
      validB_q    <= rdB;
      collision_q <= wrA & wrB & (addr_A == addr_B);
      if (rdA) dataA_q <= rdDataA;
      if (rdB) dataB_q <= rdDataB;
    end
  end

  assign collision = collision_q;

`ifdef DP_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dataA2_q, dataB2_q;
  logic                  validA2_q, validB2_q;

  // Second output stage; a read in flight when a clear starts is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataA2_q  <= '0;
      dataB2_q  <= '0;
      validA2_q <= 1'b0;
      validB2_q <= 1'b0;
    end else begin
      validA2_q <= validA_q & ~busy;
      validB2_q <= validB_q & ~busy;
      if (validA_q) dataA2_q <= dataA_q;
      if (validB_q) dataB2_q <= dataB_q;
    end
  end

  assign data_out_A = dataA2_q;
  assign data_out_B = dataB2_q;
  assign valid_A    = validA2_q;
  assign valid_B    = validB2_q;
`else
  assign data_out_A = dataA_q;
  assign data_out_B = dataB_q;
  assign valid_A    = validA_q;
  assign valid_B    = validB_q;
`endif

endmodule

// File: tb/tb_dp_ram_clr.sv
// tb_dp_ram_clr: self-checking bench for dp_ram_clr (default 16x64, old-data
// read-during-write). Reads push the expected word and its arrival cycle into
// a per-port queue; a monitor pops and compares whenever valid is seen.
module tb_dp_ram_clr;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 64;
  localparam int RDW   = 0;
`ifdef DP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          en_A = 1'b0, we_A = 1'b0, en_B = 1'b0, we_B = 1'b0;
  logic [NB-1:0] be_A = '0, be_B = '0;
  logic [AW-1:0] addr_A = '0, addr_B = '0;
  logic [DW-1:0] data_in_A = '0, data_in_B = '0;
  logic [DW-1:0] data_out_A, data_out_B;
  logic          valid_A, valid_B, busy, collision;

  typedef struct packed {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          qA[$];
  exp_t          qB[$];
  exp_t          eA, eB;
  logic [DW-1:0] mdl [DEPTH];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  dp_ram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(RDW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .en_A(en_A), .we_A(we_A), .be_A(be_A), .addr_A(addr_A),
    .data_in_A(data_in_A), .data_out_A(data_out_A), .valid_A(valid_A),
    .en_B(en_B), .we_B(we_B), .be_B(be_B), .addr_B(addr_B),
    .data_in_B(data_in_B), .data_out_B(data_out_B), .valid_B(valid_B),
    .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] o,
                                               input logic [DW-1:0] n,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Advance one cycle and return every request line to idle.
  task automatic tick();
    @(negedge clk);
    en_A = 1'b0; we_A = 1'b0;
    en_B = 1'b0; we_B = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic readA(input logic [AW-1:0] a, input logic [DW-1:0] expd);
    en_A = 1'b1; we_A = 1'b0; addr_A = a;
    qA.push_back('{data: expd, due: cyc + LAT});
  endtask

  task automatic readB(input logic [AW-1:0] a, input logic [DW-1:0] expd);
    en_B = 1'b1; we_B = 1'b0; addr_B = a;
    qB.push_back('{data: expd, due: cyc + LAT});
  endtask

  task automatic writeA(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    en_A = 1'b1; we_A = 1'b1; addr_A = a; data_in_A = d; be_A = be;
  endtask

  task automatic writeB(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    en_B = 1'b1; we_B = 1'b1; addr_B = a; data_in_B = d; be_B = be;
  endtask

  // Let outstanding reads land, then require both queues to be empty.
  task automatic drain(input string name);
    repeat (LAT + 2) tick();
    total++;
    if (qA.size() != 0 || qB.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: pending A=%0d B=%0d, required 0/0", name, qA.size(), qB.size());
    end
    qA.delete();
    qB.delete();
  endtask

  // Count busy cycles from the current negedge; bounded at 200.
  task automatic countBusy(input string name, input bit driveJunk);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (driveJunk) begin
        writeA(AW'(n), 16'hFFFF, 2'b11);
        en_B = 1'b1; we_B = 1'b0; addr_B = AW'(n);
      end
      n++;
      tick();
    end
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("[TB] FAIL %s_busy_cycles: got %0d, required %0d", name, n, DEPTH);
    end
  endtask

  task automatic readAllZero(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      readA(AW'(i), 16'h0000);
      readB(AW'(DEPTH - 1 - i), 16'h0000);
      tick();
    end
    drain(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy: got %b, required 1", busy); end
    total++;
    if (valid_A !== 1'b0 || valid_B !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_valid: got %b%b, required 00", valid_A, valid_B);
    end
    total++;
    if (collision !== 1'b0) begin bad++; $display("[TB] FAIL reset_collision: got %b, required 0", collision); end
    total++;
    if (data_out_A !== 16'h0 || data_out_B !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_data: got %h/%h, required 0000/0000", data_out_A, data_out_B);
    end
    rst = 1'b0;
    countBusy("reset", 1'b0);
    readAllZero("clear_reads");
  endtask

  task automatic test_byte_enable();
    writeA(5, 16'hABCD, 2'b11); mdl[5] = mergeBytes(mdl[5], 16'hABCD, 2'b11); tick();
    writeA(5, 16'h1234, 2'b01); mdl[5] = mergeBytes(mdl[5], 16'h1234, 2'b01); tick();
    writeB(6, 16'h7777, 2'b00); tick();
    readB(5, 16'hAB34);
    readA(6, mdl[6]);
    tick();
    drain("byte_enable");
  endtask

  task automatic test_collision();
    writeB(9, 16'h2222, 2'b11);
    writeA(9, 16'h1111, 2'b01);
    tick();
    total++;
    if (collision !== 1'b1) begin bad++; $display("[TB] FAIL collision_pulse: got %b, required 1", collision); end
    tick();
    total++;
    if (collision !== 1'b0) begin bad++; $display("[TB] FAIL collision_width: got %b, required 0", collision); end
    writeB(10, 16'h00BB, 2'b01);
    writeA(10, 16'hCC00, 2'b10);
    tick();
    total++;
    if (collision !== 1'b1) begin bad++; $display("[TB] FAIL collision_disjoint_be: got %b, required 1", collision); end
    writeA(11, 16'h1357, 2'b11);
    writeB(12, 16'h2468, 2'b11);
    tick();
    total++;
    if (collision !== 1'b0) begin bad++; $display("[TB] FAIL collision_diff_addr: got %b, required 0", collision); end
    readA(9, 16'h2211);
    readB(10, 16'hCCBB);
    tick();
    readA(12, 16'h2468);
    readB(11, 16'h1357);
    tick();
    drain("collision");
    mdl[9] = 16'h2211; mdl[10] = 16'hCCBB; mdl[11] = 16'h1357; mdl[12] = 16'h2468;
  endtask

  task automatic test_rdw();
    writeA(3, 16'h00FF, 2'b11); tick();
    readB(3, (RDW != 0) ? 16'hAAAA : 16'h00FF);
    writeA(3, 16'hAAAA, 2'b11);
    tick();
    total++;
    if (collision !== 1'b0) begin bad++; $display("[TB] FAIL rdw_no_collision: got %b, required 0", collision); end
    readA(3, (RDW != 0) ? 16'hAA55 : 16'hAAAA);
    writeB(3, 16'h5555, 2'b01);
    tick();
    readA(3, 16'hAA55);
    readB(3, 16'hAA55);
    tick();
    drain("rdw");
    mdl[3] = 16'hAA55;
  endtask

  task automatic test_hold();
    writeB(7, 16'h5A5A, 2'b11); tick();
    readA(7, 16'h5A5A);
    tick();
    repeat (LAT - 1) tick();
    total++;
    if (valid_A !== 1'b1 || data_out_A !== 16'h5A5A) begin
      bad++; $display("[TB] FAIL hold_arrival: got v=%b d=%h, required v=1 d=5a5a", valid_A, data_out_A);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid_A !== 1'b0 || data_out_A !== 16'h5A5A) begin
        bad++; $display("[TB] FAIL hold_idle%0d: got v=%b d=%h, required v=0 d=5a5a", i, valid_A, data_out_A);
      end
    end
    drain("hold");
  endtask

  task automatic fillAll();
    for (int i = 0; i < DEPTH / 2; i++) begin
      writeA(AW'(2 * i), {8'(i + 1), 8'hA5}, 2'b11);
      writeB(AW'(2 * i + 1), {8'hC3, 8'(i + 1)}, 2'b11);
      tick();
    end
  endtask

  task automatic test_clr();
    fillAll();
    readA(1, {8'hC3, 8'h01});
    readB(62, {8'd32, 8'hA5});
    tick();
    drain("fill");
    clr = 1'b1;
    tick();
    countBusy("clr", 1'b1);
    readAllZero("clr_reads");
    fillAll();
    clr = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    countBusy("rst_mid_clear", 1'b0);
    readAllZero("rst_mid_clear_reads");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    fork
      forever begin
        @(negedge clk);
        if (valid_A === 1'b1) begin
          total++;
          if (qA.size() == 0) begin
            bad++; $display("[TB] FAIL sb_A_unexpected: valid with data %h at cycle %0d, required no valid", data_out_A, cyc);
          end else begin
            eA = qA.pop_front();
            if (data_out_A !== eA.data || cyc != eA.due) begin
              bad++; $display("[TB] FAIL sb_A: got %h at cycle %0d, required %h at cycle %0d", data_out_A, cyc, eA.data, eA.due);
            end
          end
        end
        if (valid_B === 1'b1) begin
          total++;
          if (qB.size() == 0) begin
            bad++; $display("[TB] FAIL sb_B_unexpected: valid with data %h at cycle %0d, required no valid", data_out_B, cyc);
          end else begin
            eB = qB.pop_front();
            if (data_out_B !== eB.data || cyc != eB.due) begin
              bad++; $display("[TB] FAIL sb_B: got %h at cycle %0d, required %h at cycle %0d", data_out_B, cyc, eB.data, eB.due);
            end
          end
        end
      end
    join_none
    $display("[TB] start, read latency %0d", LAT);
    test_reset();
    test_byte_enable();
    test_collision();
    test_rdw();
    test_hold();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_ram_clr.md
Name: dp_ram_clr

Overview:
- Parametrised true dual-port RAM. It is the successor to the team's fixed 16-entry dual-port memory.
- Adds per-port enables, byte-enables, valid-tagged read data, deterministic write-collision arbitration and selectable cross-port read-during-write.
- Runs a hardware clear sequencer after reset or on request.
- Sits between two independent masters (e.g. producer/consumer engines) sharing one buffer.

Parameters:
- DATA_WIDTH, 16, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH entries.
- RDW_MODE, 0, cross-port read-during-write: 0 = old data, 1 = new data (bypass).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- clr  in  1  request full memory clear; sampled only in READY
- en_A  in  1  port A access enable
- we_A  in  1  port A write (1) / read (0); qualified by en_A
- be_A  in  DATA_WIDTH/8  port A byte enables, write only
- addr_A  in  ADDR_WIDTH  port A address
- data_in_A  in  DATA_WIDTH  port A write data
- data_out_A  out  DATA_WIDTH  port A read data
- valid_A  out  1  data_out_A holds fresh read data
- en_B, we_B, be_B, addr_B, data_in_B, data_out_B, valid_B: same as port A, for port B
- busy  out  1  clear sequence in progress; port requests ignored
- collision  out  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: data_out_A/B = 0, valid_A/B = 0, collision = 0. FSM enters CLEAR with clear counter = 0, so busy = 1 from the first edge with rst high.
- FSM has two states, CLEAR and READY.
  - CLEAR: writes 0 to mem[counter] each cycle, counter increments by 1. On counter == DEPTH-1 the FSM moves to READY. Takes exactly DEPTH cycles after rst deasserts.
  - READY, clr=1: moves to CLEAR with counter = 0. Port requests in that same cycle are still served.
- While busy:
  - en_A/en_B are ignored: no writes, valid = 0.
  - data_out holds its value.
  - collision = 0.
- rst asserted mid-clear restarts the clear from address 0.
- Read (en=1, we=0, READY): data_out <= mem[addr] at the next edge, valid = 1 for that one cycle. Latency is 1 clock.
- Write (en=1, we=1, READY): for each byte i with be[i]=1, mem[addr] byte i <= data_in byte i. Other bytes are unchanged.
  - valid = 0 and data_out holds.
  - be all-zero is a legal no-op write.
- Idle (en=0): valid = 0 and data_out holds its last value.
- Both ports write the same address in the same cycle:
  - Port A wins on every byte enabled in be_A.
  - Bytes enabled only in be_B take port B data.
  - collision pulses 1 for one cycle, even if the byte-enable sets do not overlap.
- One port writes address X while the other reads X in the same cycle:
  - RDW_MODE=0: the reader gets the pre-write contents.
  - RDW_MODE=1: the reader gets the post-write contents, byte-merged per the writer's be.
  - No collision pulse.
- Both ports read the same address: both get identical data; no collision.
- Address arithmetic: the clear counter is ADDR_WIDTH+1 bits wide so the DEPTH-1 end condition is exact. Port addresses are always in range.

Optional Feature:
- Macro: DP_RAM_OUT_REG_EN.
- Defined:
  - Adds a second output register stage on data_out_A/B and valid_A/B; read latency becomes 2 clocks.
  - The valid pipeline resets to 0 and is flushed (0) while busy.
  - The stage-2 data register loads only when its stage-1 valid is 1, otherwise it holds.
  - collision timing is unchanged (1 cycle after the write).
- Undefined: latency is 1 as specified above.

Test Plan:
- Clear after reset: with ADDR_WIDTH=6, release rst, then poll busy. Required: busy high exactly 64 cycles. Then reading every address on both ports returns 0x0000 with valid=1, one cycle after each request.
- Byte-enable write: write 0xABCD with be=2'b11 at addr 5, then 0x1234 with be=2'b01. Required: read of addr 5 returns 0xAB34.
- Write collision: in one cycle, A writes 0x1111 (be=2'b01) and B writes 0x2222 (be=2'b11), both to addr 9. Required: mem[9] = 0x2211 and collision=1 for exactly one cycle.
- Read-during-write: mem[3] = 0x00FF; A writes 0xAAAA to addr 3 while B reads addr 3. Required: data_out_B = 0x00FF with RDW_MODE=0, 0xAAAA with RDW_MODE=1.
- Mid-operation clr/rst: fill addr 0..63 with nonzero data, pulse clr in READY. Required: busy for 64 cycles and all reads return 0. Asserting rst at cycle 20 of the clear restarts the full 64-cycle clear.
- Hold and latency: read addr 7 (= 0x5A5A), then idle 3 cycles. Required: valid high 1 cycle and data_out stays 0x5A5A. With DP_RAM_OUT_REG_EN defined, valid and data appear 2 cycles after the request.
